apb_regfile_slave: RTL and testbench
====================================

Name: apb_regfile_slave

Overview:
- Parametrised APB3 slave register file; next generation of the team's fixed 12-register test slave.
- Adds configurable register count, configurable wait states (including zero-wait), byte strobes, read-only registers fed from hardware, alignment and range error decoding, and per-register write strobes.
- Sits behind the APB bridge/decoder as a generic peripheral control/status block.

Parameters:
- ADDR_WIDTH, 32, PADDR width.
- DATA_WIDTH, 32, PWDATA/PRDATA width; must be 8, 16 or 32.
- NUM_REGS, 12, number of registers, 1..64.
- WAIT_CYCLES, 3, wait states inserted in every access phase, 0..15.
- RO_MASK, {NUM_REGS{1'b0}}, bit n=1 makes register n read-only; its read value comes from i_ro_data.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_psel  in  1  APB select.
- i_penable  in  1  APB enable.
- i_pwrite  in  1  1=write, 0=read.
- i_paddr  in  ADDR_WIDTH  byte address.
- i_pwdata  in  DATA_WIDTH  write data.
- i_pstrb  in  DATA_WIDTH/8  byte-lane write strobes.
- o_pready  out  1  transfer complete.
- o_prdata  out  DATA_WIDTH  read data.
- o_pslverr  out  1  transfer error, valid with o_pready.
- i_ro_data  in  NUM_REGS*DATA_WIDTH  hardware values for read-only registers; slice n = register n.
- o_regs  out  NUM_REGS*DATA_WIDTH  current register contents, flattened; slice n = register n.
- o_reg_wr  out  NUM_REGS  one-cycle pulse per register on committed write.

Behaviour:
- Reset (asynchronous, active-low, on i_reset_n; clock i_clk):
  - All RW registers = 0; o_regs slices for RO registers follow i_ro_data.
  - o_pready=0, o_prdata=0, o_pslverr=0, o_reg_wr=0.
  - FSM in IDLE; wait counter = 0.
- Address decode:
  - LSB = log2(DATA_WIDTH/8); idx = i_paddr >> LSB.
  - Error if idx >= NUM_REGS, if i_paddr[LSB-1:0] != 0, or if the access is a write to a register with its RO_MASK bit set.
- FSM states: IDLE, ACCESS.
  - IDLE -> ACCESS when i_psel=1 and i_penable=0 (setup phase). Clear the counter; capture addr/write/wdata/strb/error into registers.
  - In ACCESS the counter increments each cycle while cnt < WAIT_CYCLES.
  - o_pready = (state==ACCESS && cnt==WAIT_CYCLES), decoded from registered state/counter only, so there is no combinational path from inputs.
  - Completion cycle (i_psel & i_penable & o_pready):
    - Write without error: each byte lane with its strobe set is updated in the same clock edge, and the matching o_reg_wr bit pulses for exactly the next cycle.
    - Read without error: o_prdata = register value (RW) or i_ro_data slice (RO), sampled in the completion cycle.
    - Error: no register update, no o_reg_wr, o_pslverr=1, o_prdata=0.
  - After completion go to ACCESS again if i_psel=1 and i_penable=0 (back-to-back setup), otherwise IDLE.
- Latency:
  - WAIT_CYCLES=0: setup + 1 access cycle.
  - Otherwise: setup + (WAIT_CYCLES+1) access cycles.
- o_prdata and o_pslverr are 0 whenever o_pready=0.
- i_pstrb=0 on a valid write completes OKAY with no data change, but o_reg_wr still pulses.
- Protocol abort: i_psel falls while in ACCESS before completion -> return to IDLE, no write, no strobe, no error.
- Changes to i_paddr, i_pwrite or i_pwdata during ACCESS are ignored; the setup-phase capture is used.
- i_ro_data may change at any time; reads sample it in the completion cycle.
- Reset asserted mid-transfer: immediate return to reset values; a partial write never commits.

Decomposition:
- Shared package apb_pkg:
  - FSM state encoding (IDLE, ACCESS).
  - APB_RESP_OKAY/APB_RESP_ERR constants.
  - clog2 helper function.
- One natural sub-module, apb_wait_ctrl: the wait counter and ready generation, parametrised by WAIT_CYCLES.
- Register array, decode and mux stay in the top.

Test Plan:
- WAIT_CYCLES=3, write 0xDEADBEEF to 0x08 with strb=4'hF -> o_pready high on 4th access cycle; o_regs slice 2 = 0xDEADBEEF; o_reg_wr[2] pulses once; o_pslverr=0.
- Write 0x11223344 to 0x04 with strb=4'b0101, register preloaded with 0xAABBCCDD -> register = 0xAA22CC44; read of 0x04 returns 0xAA22CC44.
- Out-of-range and misaligned accesses:
  - Read of 0x30 (NUM_REGS=12) -> o_pready with o_pslverr=1, o_prdata=0.
  - Write to 0x02 -> o_pslverr=1; all registers unchanged.
- RO_MASK bit 5 set, i_ro_data slice5=0x0000CAFE:
  - Read 0x14 -> 0x0000CAFE.
  - Write 0x14 -> o_pslverr=1, no o_reg_wr.
- WAIT_CYCLES=0, back-to-back write then read at 0x00 -> each transfer takes 2 cycles; read returns the written value; no idle cycle is required between transfers.
- Abort and reset during ACCESS:
  - Drop i_psel during ACCESS of a write -> no update, FSM in IDLE.
  - Assert i_reset_n=0 during a wait state -> all outputs 0 immediately; the next transfer behaves normally.

Source files
------------

// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_pkg
// Purpose  : Shared APB slave types: FSM encoding, response codes, clog2 helper.
// Revision : 1.0
// ============================================================================
package apb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_t;

    localparam logic APB_RESP_OKAY = 1'b0;
    localparam logic APB_RESP_ERR  = 1'b1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_wait_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : apb_wait_ctrl
// Purpose  : Access-phase wait-state counter; PREADY decoded from registers only.
// Revision : 1.0
// ============================================================================
module apb_wait_ctrl #(
    parameter int WAIT_CYCLES = 3
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_start,
    input  logic i_in_access,
    output logic o_pready
);

    localparam logic [3:0] c_wait = WAIT_CYCLES[3:0];

    logic [3:0] r_cnt;

    // Counter saturates at WAIT_CYCLES, so != is equivalent to < here.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt <= 4'd0;
        end else if (i_start) begin
            r_cnt <= 4'd0;
        end else if (i_in_access && (r_cnt != c_wait)) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_pready = i_in_access && (r_cnt == c_wait);

endmodule
`default_nettype wire

// File: rtl/apb_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module   : apb_regfile_slave
// Purpose  : Parametrised APB3 register file with wait states, strobes, RO regs.
// Revision : 1.0
// ============================================================================
module apb_regfile_slave
    import apb_pkg::*;
#(
    parameter int                   ADDR_WIDTH  = 32,
    parameter int                   DATA_WIDTH  = 32,
    parameter int                   NUM_REGS    = 12,
    parameter int                   WAIT_CYCLES = 3,
    parameter logic [NUM_REGS-1:0]  RO_MASK     = {NUM_REGS{1'b0}}
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic                           i_psel,
    input  logic                           i_penable,
    input  logic                           i_pwrite,
    input  logic [ADDR_WIDTH-1:0]          i_paddr,
    input  logic [DATA_WIDTH-1:0]          i_pwdata,
    input  logic [DATA_WIDTH/8-1:0]        i_pstrb,
    output logic                           o_pready,
    output logic [DATA_WIDTH-1:0]          o_prdata,
    output logic                           o_pslverr,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] i_ro_data,
    output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs,
    output logic [NUM_REGS-1:0]            o_reg_wr
);

    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int LSB       = clog2(NUM_LANES);
    localparam int IDX_W     = (NUM_REGS > 1) ? clog2(NUM_REGS) : 1;
    localparam int RO_PAD_W  = 1 << IDX_W;
    localparam logic [RO_PAD_W-1:0] c_ro_pad = RO_PAD_W'(RO_MASK);

    apb_state_t r_state, w_state_next;

    logic [ADDR_WIDTH-1:0]  w_idx_full;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_misalign, w_out_of_range, w_err;
    logic                   w_setup, w_done, w_capture, w_pready;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_write, r_err;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [NUM_LANES-1:0]   r_strb;
    logic [DATA_WIDTH-1:0]  r_regs   [NUM_REGS];
    logic [DATA_WIDTH-1:0]  w_rd_vals[NUM_REGS];
    logic [DATA_WIDTH-1:0]  w_rd_sel;
    logic [NUM_REGS-1:0]    r_reg_wr;
    logic                   w_unused_ro;

    assign w_idx_full     = i_paddr >> LSB;
    assign w_idx          = w_idx_full[IDX_W-1:0];
    assign w_out_of_range = (w_idx_full >= ADDR_WIDTH'(NUM_REGS));

    generate
        if (LSB == 0) begin : g_no_align
            assign w_misalign = 1'b0;
        end else begin : g_align
            assign w_misalign = |i_paddr[LSB-1:0];
        end
    endgenerate

    assign w_err   = w_out_of_range || w_misalign || (i_pwrite && c_ro_pad[w_idx]);
    assign w_setup = i_psel && !i_penable;
    assign w_done  = i_psel && i_penable && w_pready;

    // Completion always returns to IDLE; IDLE doubles as the setup phase, so a
    // back-to-back setup is accepted on the very next cycle without a gap.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_setup) begin
                    w_state_next = ST_ACCESS;
                    w_capture    = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (!i_psel || w_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_idx   <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_strb  <= '0;
            r_err   <= APB_RESP_OKAY;
        end else if (w_capture) begin
            r_idx   <= w_idx;
            r_write <= i_pwrite;
            r_wdata <= i_pwdata;
            r_strb  <= i_pstrb;
            r_err   <= w_err ? APB_RESP_ERR : APB_RESP_OKAY;
        end
    end

    apb_wait_ctrl #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_ctrl (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_start     (w_capture),
        .i_in_access (r_state == ST_ACCESS),
        .o_pready    (w_pready)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int n = 0; n < NUM_REGS; n++) begin
                r_regs[n] <= '0;
            end
            r_reg_wr <= '0;
        end else begin
            r_reg_wr <= '0;
            if (w_done && r_write && (r_err == APB_RESP_OKAY)) begin
                for (int n = 0; n < NUM_REGS; n++) begin
                    if (r_idx == IDX_W'(n)) begin
                        r_reg_wr[n] <= 1'b1;
                        for (int b = 0; b < NUM_LANES; b++) begin
                            if (r_strb[b]) begin
                                r_regs[n][b*8 +: 8] <= r_wdata[b*8 +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    generate
        for (genvar n = 0; n < NUM_REGS; n++) begin : g_regs
            if (RO_MASK[n]) begin : g_ro
                assign w_rd_vals[n] = i_ro_data[n*DATA_WIDTH +: DATA_WIDTH];
            end else begin : g_rw
                assign w_rd_vals[n] = r_regs[n];
            end
            assign o_regs[n*DATA_WIDTH +: DATA_WIDTH] = w_rd_vals[n];
        end
    endgenerate

    // Slices of i_ro_data belonging to RW registers are intentionally ignored.
    assign w_unused_ro = ^i_ro_data;

    always_comb begin
        w_rd_sel = '0;
        for (int n = 0; n < NUM_REGS; n++) begin
            if (r_idx == IDX_W'(n)) begin
                w_rd_sel = w_rd_vals[n];
            end
        end
    end

    assign o_pready  = w_pready;
    assign o_pslverr = w_pready ? r_err : APB_RESP_OKAY;
    assign o_prdata  = (w_pready && !r_write && (r_err == APB_RESP_OKAY)) ? w_rd_sel : '0;
    assign o_reg_wr  = r_reg_wr;

endmodule
`default_nettype wire

// File: tb/tb_apb_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_regfile_slave
// Purpose  : Directed self-checking bench for apb_regfile_slave (3-wait and 0-wait).
// Revision : 1.0
// ============================================================================
module tb_apb_regfile_slave;

    localparam int NR = 12;
    localparam int DW = 32;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               psel3, psel0, penable, pwrite;
    logic [31:0]        paddr, pwdata;
    logic [3:0]         pstrb;
    logic               pready3, pslverr3, pready0, pslverr0;
    logic [31:0]        prdata3, prdata0;
    logic [NR*DW-1:0]   ro3, ro0, regs3, regs0;
    logic [NR-1:0]      reg_wr3, reg_wr0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    apb_regfile_slave #(
        .ADDR_WIDTH (32), .DATA_WIDTH (DW), .NUM_REGS (NR),
        .WAIT_CYCLES (3), .RO_MASK (12'h020)
    ) dut3 (
        .i_clk (clk), .i_reset_n (reset_n), .i_psel (psel3), .i_penable (penable),
        .i_pwrite (pwrite), .i_paddr (paddr), .i_pwdata (pwdata), .i_pstrb (pstrb),
        .o_pready (pready3), .o_prdata (prdata3), .o_pslverr (pslverr3),
        .i_ro_data (ro3), .o_regs (regs3), .o_reg_wr (reg_wr3)
    );

    apb_regfile_slave #(
        .ADDR_WIDTH (32), .DATA_WIDTH (DW), .NUM_REGS (NR),
        .WAIT_CYCLES (0), .RO_MASK (12'h000)
    ) dut0 (
        .i_clk (clk), .i_reset_n (reset_n), .i_psel (psel0), .i_penable (penable),
        .i_pwrite (pwrite), .i_paddr (paddr), .i_pwdata (pwdata), .i_pstrb (pstrb),
        .o_pready (pready0), .o_prdata (prdata0), .o_pslverr (pslverr0),
        .i_ro_data (ro0), .o_regs (regs0), .o_reg_wr (reg_wr0)
    );

    // Drives one transfer starting just after a rising edge; returns just after
    // the edge that follows the completion cycle, leaving the bus idle.
    task automatic xfer(input bit on0, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        output logic [31:0] rdata, output logic err,
                        output int cycles, output bit idle_bad);
        if (on0) psel0 = 1'b1; else psel3 = 1'b1;
        penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        rdata = '0; err = 1'b0; cycles = 0; idle_bad = 1'b0;
        @(posedge clk); #1 penable = 1'b1;
        while (cycles < 40) begin
            @(negedge clk);
            cycles++;
            if ((on0 ? pready0 : pready3) === 1'b1) begin
                rdata = on0 ? prdata0 : prdata3;
                err   = on0 ? pslverr0 : pslverr3;
                break;
            end
            if ((on0 ? prdata0 : prdata3) !== 32'h0 || (on0 ? pslverr0 : pslverr3) !== 1'b0)
                idle_bad = 1'b1;
        end
        @(posedge clk); #1 psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        logic [NR*DW-1:0] exp;
        reset_n = 1'b0; psel3 = 1'b0; psel0 = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
        ro0 = '0; ro3 = '0; ro3[5*DW +: DW] = 32'h0000CAFE;
        repeat (3) @(posedge clk);
        @(negedge clk);
        exp = '0; exp[5*DW +: DW] = 32'h0000CAFE;
        n_checks++;
        if (regs3 !== exp) begin n_fail++; $display("FAIL reset_regs3 got=%h exp=%h", regs3, exp); end
        n_checks++;
        if ({pready3, pslverr3, prdata3, reg_wr3} !== '0) begin
            n_fail++; $display("FAIL reset_outs3 got rdy=%b err=%b rd=%h wr=%h exp all 0", pready3, pslverr3, prdata3, reg_wr3);
        end
        n_checks++;
        if ({pready0, pslverr0, prdata0, reg_wr0, regs0} !== '0) begin
            n_fail++; $display("FAIL reset_outs0 got rdy=%b rd=%h wr=%h exp all 0", pready0, prdata0, reg_wr0);
        end
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_full();
        logic [31:0] rd; logic err; int cyc; bit ib;
        xfer(1'b0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, rd, err, cyc, ib);
        @(negedge clk);
        n_checks++;
        if (cyc !== 4) begin n_fail++; $display("FAIL wr_latency got=%0d exp=4", cyc); end
        n_checks++;
        if (err !== 1'b0 || ib !== 1'b0) begin n_fail++; $display("FAIL wr_err got err=%b idle_bad=%b exp 0/0", err, ib); end
        n_checks++;
        if (regs3[2*DW +: DW] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_reg2 got=%h exp=deadbeef", regs3[2*DW +: DW]); end
        n_checks++;
        if (reg_wr3 !== 12'h004) begin n_fail++; $display("FAIL wr_pulse got=%h exp=004", reg_wr3); end
        @(negedge clk);
        n_checks++;
        if (reg_wr3 !== 12'h000) begin n_fail++; $display("FAIL wr_pulse_end got=%h exp=000", reg_wr3); end
        @(posedge clk); #1;
    endtask

    task automatic test_strobe();
        logic [31:0] rd; logic err; int cyc; bit ib;
        xfer(1'b0, 1'b1, 32'h04, 32'hAABBCCDD, 4'hF, rd, err, cyc, ib);
        xfer(1'b0, 1'b1, 32'h04, 32'h11223344, 4'b0101, rd, err, cyc, ib);
        @(negedge clk);
        n_checks++;
        if (regs3[1*DW +: DW] !== 32'hAA22CC44) begin n_fail++; $display("FAIL strb_reg1 got=%h exp=aa22cc44", regs3[1*DW +: DW]); end
        @(posedge clk); #1;
        xfer(1'b0, 1'b0, 32'h04, 32'h0, 4'h0, rd, err, cyc, ib);
        n_checks++;
        if (rd !== 32'hAA22CC44 || err !== 1'b0) begin n_fail++; $display("FAIL strb_read got=%h err=%b exp=aa22cc44/0", rd, err); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err; int cyc; bit ib;
        logic [NR*DW-1:0] exp;
        xfer(1'b0, 1'b0, 32'h30, 32'h0, 4'h0, rd, err, cyc, ib);
        n_checks++;
        if (err !== 1'b1 || rd !== 32'h0 || cyc !== 4 || ib !== 1'b0) begin
            n_fail++; $display("FAIL oor_read got err=%b rd=%h cyc=%0d ib=%b exp 1/0/4/0", err, rd, cyc, ib);
        end
        xfer(1'b0, 1'b1, 32'h02, 32'h55555555, 4'hF, rd, err, cyc, ib);
        @(negedge clk);
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL misalign_wr_err got=%b exp=1", err); end
        exp = '0;
        exp[1*DW +: DW] = 32'hAA22CC44;
        exp[2*DW +: DW] = 32'hDEADBEEF;
        exp[5*DW +: DW] = 32'h0000CAFE;
        n_checks++;
        if (regs3 !== exp || reg_wr3 !== 12'h000) begin
            n_fail++; $display("FAIL misalign_no_update got wr=%h regs=%h exp wr=000 regs=%h", reg_wr3, regs3, exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ro();
        logic [31:0] rd; logic err; int cyc; bit ib;
        xfer(1'b0, 1'b0, 32'h14, 32'h0, 4'h0, rd, err, cyc, ib);
        n_checks++;
        if (rd !== 32'h0000CAFE || err !== 1'b0) begin n_fail++; $display("FAIL ro_read got=%h err=%b exp=0000cafe/0", rd, err); end
        ro3[5*DW +: DW] = 32'h0000BEEF;
        xfer(1'b0, 1'b0, 32'h14, 32'h0, 4'h0, rd, err, cyc, ib);
        n_checks++;
        if (rd !== 32'h0000BEEF) begin n_fail++; $display("FAIL ro_live got=%h exp=0000beef", rd); end
        xfer(1'b0, 1'b1, 32'h14, 32'h12345678, 4'hF, rd, err, cyc, ib);
        @(negedge clk);
        n_checks++;
        if (err !== 1'b1 || reg_wr3 !== 12'h000 || regs3[5*DW +: DW] !== 32'h0000BEEF) begin
            n_fail++; $display("FAIL ro_write got err=%b wr=%h reg5=%h exp 1/000/0000beef", err, reg_wr3, regs3[5*DW +: DW]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_strobe();
        logic [31:0] rd; logic err; int cyc; bit ib;
        xfer(1'b0, 1'b1, 32'h0C, 32'hFFFFFFFF, 4'h0, rd, err, cyc, ib);
        @(negedge clk);
        n_checks++;
        if (err !== 1'b0 || reg_wr3 !== 12'h008 || regs3[3*DW +: DW] !== 32'h0) begin
            n_fail++; $display("FAIL zero_strb got err=%b wr=%h reg3=%h exp 0/008/0", err, reg_wr3, regs3[3*DW +: DW]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic err; int cyc; bit ib;
        bit seen;
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08;
        pwdata = 32'h0BADF00D; pstrb = 4'hF;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 psel3 = 1'b0; penable = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (reg_wr3 !== 12'h000 || pready3 !== 1'b0 || pslverr3 !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen || regs3[2*DW +: DW] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL abort_no_write got activity=%b reg2=%h exp 0/deadbeef", seen, regs3[2*DW +: DW]);
        end
        @(posedge clk); #1;
        xfer(1'b0, 1'b0, 32'h08, 32'h0, 4'h0, rd, err, cyc, ib);
        n_checks++;
        if (rd !== 32'hDEADBEEF || cyc !== 4 || err !== 1'b0) begin
            n_fail++; $display("FAIL abort_recover got rd=%h cyc=%0d err=%b exp deadbeef/4/0", rd, cyc, err);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic err; int cyc_w, cyc_r; bit ib;
        xfer(1'b1, 1'b1, 32'h00, 32'h12345678, 4'hF, rd, err, cyc_w, ib);
        xfer(1'b1, 1'b0, 32'h00, 32'h0, 4'h0, rd, err, cyc_r, ib);
        n_checks++;
        if (cyc_w !== 1 || cyc_r !== 1) begin n_fail++; $display("FAIL b2b_latency got w=%0d r=%0d exp 1/1", cyc_w, cyc_r); end
        n_checks++;
        if (rd !== 32'h12345678 || err !== 1'b0) begin n_fail++; $display("FAIL b2b_read got=%h err=%b exp=12345678/0", rd, err); end
        n_checks++;
        if (regs0[0 +: DW] !== 32'h12345678) begin n_fail++; $display("FAIL b2b_reg0 got=%h exp=12345678", regs0[0 +: DW]); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic err; int cyc; bit ib;
        logic [NR*DW-1:0] exp;
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h00;
        pwdata = 32'h00000077; pstrb = 4'hF;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 reset_n = 1'b0;
        #1;
        exp = '0; exp[5*DW +: DW] = 32'h0000BEEF;
        n_checks++;
        if (regs3 !== exp || {pready3, pslverr3, prdata3, reg_wr3} !== '0) begin
            n_fail++; $display("FAIL mid_reset got rdy=%b err=%b wr=%h regs=%h exp zeros regs=%h", pready3, pslverr3, reg_wr3, regs3, exp);
        end
        psel3 = 1'b0; penable = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (regs3[0 +: DW] !== 32'h0 || reg_wr3 !== 12'h000) begin
            n_fail++; $display("FAIL mid_reset_no_commit got reg0=%h wr=%h exp 0/000", regs3[0 +: DW], reg_wr3);
        end
        @(posedge clk); #1;
        xfer(1'b0, 1'b1, 32'h00, 32'h5A5A5A5A, 4'hF, rd, err, cyc, ib);
        @(negedge clk);
        n_checks++;
        if (cyc !== 4 || err !== 1'b0 || regs3[0 +: DW] !== 32'h5A5A5A5A || reg_wr3 !== 12'h001) begin
            n_fail++; $display("FAIL post_reset_xfer got cyc=%0d err=%b reg0=%h wr=%h exp 4/0/5a5a5a5a/001", cyc, err, regs3[0 +: DW], reg_wr3);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_write_full();
        test_strobe();
        test_errors();
        test_ro();
        test_zero_strobe();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
